lvt_2w1r_read_select: RTL and testbench

LVT_2W1R_READ_SELECT -- requirements
Module: lvt_2w1r_read_select

---
 rtl/lvt_2w1r_read_select.sv | 102 ++++++++++
 tb/tb_lvt_2w1r_read_select.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/lvt_2w1r_read_select.sv
// Live-value-table read selector for a 2-write/1-read memory built from two 1W1R banks.
// Define LVT_WRITE_FORWARD_EN to forward same-cycle write data to a matching read.
module lvt_2w1r_read_select #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              we0,
    input  logic [ADDR_W-1:0] waddr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] waddr1,
    input  logic [DATA_W-1:0] wdata1,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] raddr,
    input  logic [DATA_W-1:0] bank0_rdata,
    input  logic [DATA_W-1:0] bank1_rdata,
    output logic [DATA_W-1:0] rdata,
    output logic              rd_valid,
    output logic              wr_conflict
);

    logic [DEPTH-1:0] lvt_reg;
    logic [DEPTH-1:0] lvt_next;
    logic             sel_reg;
    logic             rd_valid_reg;
    logic             wr_conflict_reg;

    // Port 1 takes priority when both ports hit the same entry.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_lvt
            assign lvt_next[gi] = (we1 && (waddr1 == ADDR_W'(gi))) ? 1'b1 :
                                  (we0 && (waddr0 == ADDR_W'(gi))) ? 1'b0 :
                                  lvt_reg[gi];
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            lvt_reg         <= '0;
            sel_reg         <= 1'b0;
            rd_valid_reg    <= 1'b0;
            wr_conflict_reg <= 1'b0;
        end else begin
            lvt_reg         <= lvt_next;
            rd_valid_reg    <= rd_en;
            wr_conflict_reg <= we0 && we1 && (waddr0 == waddr1);
            // Sample the pre-write entry so the choice matches the banks' old-data read.
            if (rd_en) begin
                sel_reg <= lvt_reg[raddr];
            end
        end
    end

`ifdef LVT_WRITE_FORWARD_EN
    logic              fwd_hit_reg;
    logic [DATA_W-1:0] fwd_data_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            fwd_hit_reg  <= 1'b0;
            fwd_data_reg <= '0;
        end else if (rd_en && we1 && (waddr1 == raddr)) begin
            fwd_hit_reg  <= 1'b1;
            fwd_data_reg <= wdata1;
        end else if (rd_en && we0 && (waddr0 == raddr)) begin
            fwd_hit_reg  <= 1'b1;
            fwd_data_reg <= wdata0;
        end else begin
            fwd_hit_reg  <= 1'b0;
        end
    end

    always_comb begin
        rdata = '0;
        if (rd_valid_reg) begin
            if (fwd_hit_reg) begin
                rdata = fwd_data_reg;
            end else begin
                rdata = sel_reg ? bank1_rdata : bank0_rdata;
            end
        end
    end
`else
    // Write data only reaches the banks when forwarding is compiled out.
    logic unused_wdata;
    assign unused_wdata = ^{wdata0, wdata1};

    always_comb begin
        rdata = '0;
        if (rd_valid_reg) begin
            rdata = sel_reg ? bank1_rdata : bank0_rdata;
        end
    end
`endif

    assign rd_valid    = rd_valid_reg;
    assign wr_conflict = wr_conflict_reg;

endmodule

// File: tb/tb_lvt_2w1r_read_select.sv
// Randomized bench for lvt_2w1r_read_select with behavioural banks and a newest-value memory model.
module tb_lvt_2w1r_read_select;

`ifdef LVT_WRITE_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        we0, we1, rd_en;
    logic [4:0]  waddr0, waddr1, raddr;
    logic [31:0] wdata0, wdata1;
    logic [31:0] bank0_rdata, bank1_rdata;
    logic [31:0] rdata;
    logic        rd_valid, wr_conflict;

    int errors = 0;
    int checks = 0;
    int txn    = 0;

    logic [31:0] bank0_mem [32];
    logic [31:0] bank1_mem [32];
    // Model: bank 0 contents as known to the environment, and the newest value per address.
    logic [31:0] sh0  [32];
    logic [31:0] live [32];

    logic        ev, ec;
    logic [31:0] ed;

    always #5 clk = ~clk;

    // Banks: registered read with old-data on read-during-write, no reset.
    always @(posedge clk) begin
        bank0_rdata <= bank0_mem[raddr];
        bank1_rdata <= bank1_mem[raddr];
        if (we0) bank0_mem[waddr0] <= wdata0;
        if (we1) bank1_mem[waddr1] <= wdata1;
    end

    lvt_2w1r_read_select #(.ADDR_W(5), .DATA_W(32), .DEPTH(32)) dut (
        .clock       (clk),
        .reset       (rst),
        .we0         (we0),
        .waddr0      (waddr0),
        .wdata0      (wdata0),
        .we1         (we1),
        .waddr1      (waddr1),
        .wdata1      (wdata1),
        .rd_en       (rd_en),
        .raddr       (raddr),
        .bank0_rdata (bank0_rdata),
        .bank1_rdata (bank1_rdata),
        .rdata       (rdata),
        .rd_valid    (rd_valid),
        .wr_conflict (wr_conflict)
    );

    // Drive one cycle, predict outputs for the following cycle, update the model.
    task automatic do_cycle(input logic r, input logic w0, input logic [4:0] a0, input logic [31:0] d0,
                            input logic w1, input logic [4:0] a1, input logic [31:0] d1,
                            input logic re, input logic [4:0] ra,
                            output logic exp_v, output logic [31:0] exp_d, output logic exp_c);
        rst = r; we0 = w0; waddr0 = a0; wdata0 = d0;
        we1 = w1; waddr1 = a1; wdata1 = d1; rd_en = re; raddr = ra;
        exp_v = re && !r;
        exp_d = 32'h0;
        if (exp_v) begin
            if (FWD && w1 && a1 == ra)      exp_d = d1;
            else if (FWD && w0 && a0 == ra) exp_d = d0;
            else                            exp_d = live[ra];
        end
        exp_c = !r && w0 && w1 && (a0 == a1);
        if (w0) sh0[a0] = d0;
        if (r) begin
            for (int i = 0; i < 32; i++) live[i] = sh0[i];
        end else begin
            if (w0) live[a0] = d0;
            if (w1) live[a1] = d1;
        end
        @(posedge clk);
        #1;
        txn++;
        $display("txn %0d: rst=%0b we0=%0b@%0d we1=%0b@%0d rd_en=%0b@%0d -> rd_valid=%0b rdata=%08h wr_conflict=%0b",
                 txn, r, w0, a0, w1, a1, re, ra, rd_valid, rdata, wr_conflict);
    endtask

    task automatic test_reset();
        for (int k = 0; k < 2; k++) begin
            do_cycle(1, 0, 0, 0, 1, 5'd1, 32'hDEAD, 1, 5'd1, ev, ed, ec);
            checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %0b want 0", rd_valid); end
            checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %08h want 0", rdata); end
            checks++; if (wr_conflict !== 1'b0) begin errors++; $display("FAIL reset_conflict got %0b want 0", wr_conflict); end
        end
        do_cycle(0, 0, 0, 0, 0, 0, 0, 1, 5'd3, ev, ed, ec);
        checks++; if (rd_valid !== ev) begin errors++; $display("FAIL first_read_valid got %0b want %0b", rd_valid, ev); end
        checks++; if (rdata !== ed) begin errors++; $display("FAIL first_read_data got %08h want %08h", rdata, ed); end
        checks++; if (wr_conflict !== ec) begin errors++; $display("FAIL first_read_conflict got %0b want %0b", wr_conflict, ec); end
    endtask

    task automatic test_port1_write();
        do_cycle(0, 0, 0, 0, 1, 5'd7, 32'hA5A5_0001, 0, 0, ev, ed, ec);
        checks++; if (rd_valid !== ev) begin errors++; $display("FAIL p1_write_valid got %0b want %0b", rd_valid, ev); end
        do_cycle(0, 0, 0, 0, 0, 0, 0, 1, 5'd7, ev, ed, ec);
        checks++; if (rdata !== ed) begin errors++; $display("FAIL p1_read_data got %08h want %08h", rdata, ed); end
        checks++; if (rd_valid !== ev) begin errors++; $display("FAIL p1_read_valid got %0b want %0b", rd_valid, ev); end
    endtask

    task automatic test_conflict();
        do_cycle(0, 1, 5'd4, 32'h11, 1, 5'd4, 32'h22, 0, 0, ev, ed, ec);
        checks++; if (wr_conflict !== ec) begin errors++; $display("FAIL conflict_pulse got %0b want %0b", wr_conflict, ec); end
        do_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, ev, ed, ec);
        checks++; if (wr_conflict !== ec) begin errors++; $display("FAIL conflict_clear got %0b want %0b", wr_conflict, ec); end
        do_cycle(0, 0, 0, 0, 0, 0, 0, 1, 5'd4, ev, ed, ec);
        checks++; if (rdata !== ed) begin errors++; $display("FAIL conflict_read got %08h want %08h", rdata, ed); end
    endtask

    task automatic test_read_during_write();
        do_cycle(0, 0, 0, 0, 1, 5'd9, 32'h99, 0, 0, ev, ed, ec);
        do_cycle(0, 1, 5'd9, 32'h55, 0, 0, 0, 1, 5'd9, ev, ed, ec);
        checks++; if (rdata !== ed) begin errors++; $display("FAIL rdw_same_cycle got %08h want %08h", rdata, ed); end
        do_cycle(0, 0, 0, 0, 0, 0, 0, 1, 5'd9, ev, ed, ec);
        checks++; if (rdata !== ed) begin errors++; $display("FAIL rdw_after got %08h want %08h", rdata, ed); end
    endtask

    task automatic test_reset_discard();
        do_cycle(0, 0, 0, 0, 1, 5'd2, 32'h2222, 0, 0, ev, ed, ec);
        do_cycle(1, 0, 0, 0, 1, 5'd5, 32'h5555, 1, 5'd2, ev, ed, ec);
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL discard_valid got %0b want 0", rd_valid); end
        do_cycle(0, 0, 0, 0, 0, 0, 0, 1, 5'd2, ev, ed, ec);
        checks++; if (rdata !== ed) begin errors++; $display("FAIL discard_read2 got %08h want %08h", rdata, ed); end
        do_cycle(0, 0, 0, 0, 0, 0, 0, 1, 5'd5, ev, ed, ec);
        checks++; if (rdata !== ed) begin errors++; $display("FAIL discard_read5 got %08h want %08h", rdata, ed); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 200; n++) begin
            logic [4:0] a0, a1, ra;
            a0 = 5'($urandom_range(0, 7)); a1 = 5'($urandom_range(0, 7)); ra = 5'($urandom_range(0, 7));
            if (n % 2 == 1) begin a0 = 5'($urandom); a1 = 5'($urandom); ra = 5'($urandom); end
            do_cycle(1'(n == 120), 1'($urandom), a0, $urandom, 1'($urandom), a1, $urandom,
                     1'($urandom), ra, ev, ed, ec);
            checks++; if (rd_valid !== ev) begin errors++; $display("FAIL rand_valid n=%0d got %0b want %0b", n, rd_valid, ev); end
            checks++; if (rdata !== ed) begin errors++; $display("FAIL rand_data n=%0d got %08h want %08h", n, rdata, ed); end
            checks++; if (wr_conflict !== ec) begin errors++; $display("FAIL rand_conflict n=%0d got %0b want %0b", n, wr_conflict, ec); end
        end
    endtask

    task automatic test_back_to_back();
        for (int a = 0; a < 32; a++) begin
            do_cycle(0, 0, 0, 0, 0, 0, 0, 1, 5'(a), ev, ed, ec);
            checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid a=%0d got %0b want 1", a, rd_valid); end
            checks++; if (rdata !== ed) begin errors++; $display("FAIL b2b_data a=%0d got %08h want %08h", a, rdata, ed); end
        end
        do_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, ev, ed, ec);
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle_valid got %0b want 0", rd_valid); end
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL b2b_idle_data got %08h want 0", rdata); end
    endtask

    initial begin
        rst = 1'b1; we0 = 1'b0; we1 = 1'b0; rd_en = 1'b0;
        waddr0 = '0; waddr1 = '0; raddr = '0; wdata0 = '0; wdata1 = '0;
        for (int i = 0; i < 32; i++) begin
            bank0_mem[i] = 32'h0B00_0000 | 32'(i);
            bank1_mem[i] = 32'h1B00_0000 | 32'(i);
            sh0[i]       = bank0_mem[i];
            live[i]      = bank0_mem[i];
        end
        test_reset();
        test_port1_write();
        test_conflict();
        test_read_during_write();
        test_reset_discard();
        test_random();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
